game_timer_ctrl: RTL and testbench

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

---
 rtl/timer_pkg.sv | 52 +++++
 rtl/tick_gen.sv | 41 ++++
 rtl/game_timer_ctrl.sv | 128 ++++++++++++
 tb/tb_game_timer_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the game countdown timer: FSM states, BCD digits
// and the clamp limits applied to loaded values.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_EXPIRED
   } timer_state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t min_tens;
      bcd_t min_ones;
      bcd_t sec_tens;
      bcd_t sec_ones;
   } bcd_time_t;

   localparam logic [6:0] MAX_MIN = 7'd99;
   localparam logic [5:0] MAX_SEC = 6'd59;

   // Two-digit BCD of a binary value 0..99, returned as {tens, ones}.
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   // One-second BCD decrement with borrow; caller guarantees t is not 00:00.
   function automatic bcd_time_t dec_time(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.sec_ones != 4'd0) begin
         r.sec_ones = t.sec_ones - 4'd1;
      end else begin
         r.sec_ones = 4'd9;
         if (t.sec_tens != 4'd0) begin
            r.sec_tens = t.sec_tens - 4'd1;
         end else begin
            r.sec_tens = 4'd5;
            if (t.min_ones != 4'd0) begin
               r.min_ones = t.min_ones - 4'd1;
            end else begin
               r.min_ones = 4'd9;
               r.min_tens = t.min_tens - 4'd1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running one-second prescaler: counts 0..TICKS_PER_SEC-1 while enabled and
// pulses tick on the wrap cycle. clr restarts the count and cancels that cycle's tick.
module tick_gen #(
   parameter int TICKS_PER_SEC = 50000000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap;

   assign wrap = (cnt_q == LAST);
   assign tick = en & ~clr & wrap;

   always_comb begin
      // NOTE: default assignment first so every path drives cnt_d -- no latch.
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = wrap ? '0 : cnt_q + CW'(1);
      end
   end

   // NOTE: non-blocking assignments for state so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/game_timer_ctrl.sv
// Game countdown timer: load mm:ss, run/pause/resume, count down in BCD once per
// second and sound the buzzer for BUZZ_SECS seconds on expiry.
module game_timer_ctrl
   import timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int BUZZ_SECS     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic       load,
   input  logic [6:0] load_min,
   input  logic [5:0] load_sec,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       paused,
   output logic       expired,
   output logic       buzzer,
   output logic       tick
);

   localparam int BW = (BUZZ_SECS > 0) ? $clog2(BUZZ_SECS + 1) : 1;
   localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_SECS);

   timer_state_t  state_q, state_d;
   bcd_time_t     time_q, time_d;
   logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
   logic          running_q, paused_q, expired_q, buzzer_q, buzzer_d;
   logic          tick_w, tick_en, tick_clr, load_ok;
   logic [6:0]    min_clamped;
   logic [5:0]    sec_clamped;

   assign tick_en     = (state_q == ST_RUN) | (state_q == ST_EXPIRED);
   assign tick_clr    = clear | ((state_q == ST_IDLE) & start);
   assign load_ok     = load & ((state_q == ST_IDLE) | (state_q == ST_EXPIRED));
   assign min_clamped = (load_min > MAX_MIN) ? MAX_MIN : load_min;
   assign sec_clamped = (load_sec > MAX_SEC) ? MAX_SEC : load_sec;

   tick_gen #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_tick_gen (
      .clk  (clk),
      .reset(reset),
      .en   (tick_en),
      .clr  (tick_clr),
      .tick (tick_w)
   );

   // An ignored load (RUN/PAUSE) does not block start/pause in the same cycle.
   always_comb begin
      state_d    = state_q;
      time_d     = time_q;
      buzz_cnt_d = buzz_cnt_q;
      if (clear) begin
         state_d    = ST_IDLE;
         time_d     = '0;
         buzz_cnt_d = '0;
      end else if (load_ok) begin
         state_d    = ST_IDLE;
         time_d     = {to_bcd(min_clamped), to_bcd({1'b0, sec_clamped})};
         buzz_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && (time_q != '0)) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (tick_w) begin
                  time_d = dec_time(time_q);
                  if (time_d == '0) begin
                     state_d    = ST_EXPIRED;
                     buzz_cnt_d = '0;
                  end else if (pause) begin
                     state_d = ST_PAUSE;
                  end
               end else if (pause) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (start) state_d = ST_RUN;
            end
            ST_EXPIRED: begin
               if (tick_w && (buzz_cnt_q < BUZZ_LAST)) buzz_cnt_d = buzz_cnt_q + BW'(1);
            end
            default: state_d = ST_IDLE;
         endcase
      end
      buzzer_d = (state_d == ST_EXPIRED) && (buzz_cnt_d < BUZZ_LAST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         time_q     <= '0;
         buzz_cnt_q <= '0;
         running_q  <= 1'b0;
         paused_q   <= 1'b0;
         expired_q  <= 1'b0;
         buzzer_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         time_q     <= time_d;
         buzz_cnt_q <= buzz_cnt_d;
         running_q  <= (state_d == ST_RUN);
         paused_q   <= (state_d == ST_PAUSE);
         expired_q  <= (state_d == ST_EXPIRED);
         buzzer_q   <= buzzer_d;
      end
   end

   assign min_tens = time_q.min_tens;
   assign min_ones = time_q.min_ones;
   assign sec_tens = time_q.sec_tens;
   assign sec_ones = time_q.sec_ones;
   assign running  = running_q;
   assign paused   = paused_q;
   assign expired  = expired_q;
   assign buzzer   = buzzer_q;
   assign tick     = tick_w;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl (TICKS_PER_SEC=4, BUZZ_SECS=3): vector table, directed
// corner sequences and random traffic against a seconds-count reference model.
module tb_game_timer_ctrl;

   localparam int TPS = 4;
   localparam int BZ  = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0, pause = 1'b0, clear = 1'b0, load = 1'b0;
   logic [6:0] load_min = '0;
   logic [5:0] load_sec = '0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, paused, expired, buzzer, tick;
   logic [20:0] obs;

   int checks = 0;
   int errors = 0;

   // Reference model: state 0=idle 1=run 2=pause 3=expired, time as total seconds.
   int m_st, m_secs, m_phase, m_buzz;

   always #5 clk = ~clk;

   game_timer_ctrl #(
      .TICKS_PER_SEC(TPS),
      .BUZZ_SECS    (BZ)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .pause   (pause),
      .clear   (clear),
      .load    (load),
      .load_min(load_min),
      .load_sec(load_sec),
      .min_tens(min_tens),
      .min_ones(min_ones),
      .sec_tens(sec_tens),
      .sec_ones(sec_ones),
      .running (running),
      .paused  (paused),
      .expired (expired),
      .buzzer  (buzzer),
      .tick    (tick)
   );

   assign obs = {min_tens, min_ones, sec_tens, sec_ones, running, paused, expired, buzzer, tick};

   typedef struct {
      logic        s, p, c, l;
      logic [6:0]  lm;
      logic [5:0]  ls;
      logic [15:0] digits;
      logic [3:0]  flags;   // {running, paused, expired, buzzer}
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [20:0] model_obs(input logic c);
      int mm, ss;
      logic tk;
      mm = m_secs / 60;
      ss = m_secs % 60;
      tk = (m_st == 1 || m_st == 3) && (m_phase == TPS - 1) && !c;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
              m_st == 1, m_st == 2, m_st == 3, (m_st == 3) && (m_buzz < BZ), tk};
   endfunction

   task automatic model_reset();
      m_st = 0; m_secs = 0; m_phase = 0; m_buzz = 0;
   endtask

   task automatic model_update(input logic s, p, c, l, input int lm, input int ls);
      logic tk;
      int   np;
      tk = (m_st == 1 || m_st == 3) && (m_phase == TPS - 1) && !c;
      if (c || (m_st == 0 && s)) np = 0;
      else if (m_st == 1 || m_st == 3) np = (m_phase + 1) % TPS;
      else np = m_phase;
      if (c) begin
         m_st = 0; m_secs = 0; m_buzz = 0;
      end else if (l && (m_st == 0 || m_st == 3)) begin
         m_st   = 0;
         m_secs = ((lm > 99) ? 99 : lm) * 60 + ((ls > 59) ? 59 : ls);
         m_buzz = 0;
      end else begin
         case (m_st)
            0: if (s && m_secs > 0) m_st = 1;
            1: begin
               if (tk) begin
                  m_secs--;
                  if (m_secs == 0) begin
                     m_st = 3; m_buzz = 0;
                  end else if (p) m_st = 2;
               end else if (p) m_st = 2;
            end
            2: if (s) m_st = 1;
            default: if (tk && m_buzz < BZ) m_buzz++;
         endcase
      end
      m_phase = np;
   endtask

   // Drive one cycle's inputs, check the pre-edge view, then advance the model.
   task automatic step(input logic s, p, c, l, input logic [6:0] lm, input logic [5:0] ls);
      @(negedge clk);
      start = s; pause = p; clear = c; load = l; load_min = lm; load_sec = ls;
      #1;
      check("cycle", 32'(obs), 32'(model_obs(c)));
      model_update(s, p, c, l, int'(lm), int'(ls));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 7'd0, 6'd0);
   endtask

   task automatic expect_post(input string name, input logic [15:0] dig, input logic [3:0] fl);
      @(posedge clk);
      #1;
      check(name, 32'(obs[20:1]), 32'({dig, fl}));
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd12,  6'd34, 16'h1234, 4'b0000};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd120, 6'd63, 16'h9959, 4'b0000};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 7'd5,   6'd5,  16'h0000, 4'b0000};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd0,   6'd0,  16'h0000, 4'b0000};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd10,  6'd0,  16'h1000, 4'b0000};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd0,   6'd0,  16'h1000, 4'b1000};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd1,   6'd1,  16'h1000, 4'b1000};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd0,   6'd0,  16'h1000, 4'b0100};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd0,   6'd0,  16'h1000, 4'b1000};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   6'd0,  16'h1000, 4'b1000};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   6'd0,  16'h0959, 4'b1000};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd0,   6'd0,  16'h0959, 4'b0100};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd0,   6'd0,  16'h0000, 4'b0000};

      // Held in reset: everything zero.
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 32'(obs), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 13; i++) begin
         step(vecs[i].s, vecs[i].p, vecs[i].c, vecs[i].l, vecs[i].lm, vecs[i].ls);
         expect_post($sformatf("vec%0d", i), vecs[i].digits, vecs[i].flags);
      end

      // 0:03 countdown to expiry, then 12 cycles of buzzer.
      step(0, 0, 0, 1, 7'd0, 6'd3);
      step(1, 0, 0, 0, 7'd0, 6'd0);
      idle(11);
      step(0, 0, 0, 0, 7'd0, 6'd0);
      expect_post("expire_entry", 16'h0000, 4'b0011);
      idle(10);
      step(0, 0, 0, 0, 7'd0, 6'd0);
      expect_post("buzz_last", 16'h0000, 4'b0011);
      step(0, 0, 0, 0, 7'd0, 6'd0);
      expect_post("buzz_off", 16'h0000, 4'b0010);
      step(1, 0, 0, 0, 7'd0, 6'd0);
      expect_post("start_in_expired", 16'h0000, 4'b0010);

      // Pause keeps the partial second; first tick two cycles after resume.
      step(0, 0, 0, 1, 7'd0, 6'd5);
      step(1, 0, 0, 0, 7'd0, 6'd0);
      step(0, 0, 0, 0, 7'd0, 6'd0);
      step(0, 1, 0, 0, 7'd0, 6'd0);
      idle(19);
      step(0, 0, 0, 0, 7'd0, 6'd0);
      expect_post("pause_hold", 16'h0005, 4'b0100);
      step(1, 0, 0, 0, 7'd0, 6'd0);
      step(0, 0, 0, 0, 7'd0, 6'd0);
      check("tick_resume_c1", 32'(tick), 32'd0);
      step(0, 0, 0, 0, 7'd0, 6'd0);
      check("tick_resume_c2", 32'(tick), 32'd1);
      expect_post("after_resume_tick", 16'h0004, 4'b1000);
      step(0, 0, 1, 0, 7'd0, 6'd0);

      // Asynchronous reset mid-run at 00:03.
      step(0, 0, 0, 1, 7'd0, 6'd5);
      step(1, 0, 0, 0, 7'd0, 6'd0);
      idle(7);
      step(0, 0, 0, 0, 7'd0, 6'd0);
      expect_post("pre_reset", 16'h0003, 4'b1000);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset", 32'(obs), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_reset();
      step(1, 0, 0, 0, 7'd0, 6'd0);
      expect_post("after_reset", 16'h0000, 4'b0000);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         logic s, p, c, l;
         logic [6:0] lm;
         logic [5:0] ls;
         s  = ($urandom_range(0, 3) == 0);
         p  = ($urandom_range(0, 5) == 0);
         c  = ($urandom_range(0, 59) == 0);
         l  = ($urandom_range(0, 9) == 0);
         lm = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
         ls = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4));
         step(s, p, c, l, lm, ls);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
